ps2_rx_frame: RTL and testbench
===============================

Name: ps2_rx_frame

Overview:
- Receive side of the PS/2 controller: deserialises device-to-host frames on the ps2_clk/ps2_data lines (start, 8 data bits LSB first, odd parity, stop).
- Presents each byte with a one-cycle strobe and error flags to FSMControlPS2, which owns the host-to-device (tx_write/tx_done) direction.
- FSMControlPS2 deasserts rx_en while it transmits, so the two directions never contend for the bus.

Parameters:
- FILTER_LEN, 8: consecutive identical system-clock samples required before the filtered ps2_clk level changes.
- TIMEOUT_CYCLES, 50000: maximum system-clock cycles between falling edges inside a frame (1 ms at 50 MHz).
- CNT_W, 16: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk, input, 1: system clock, 50 MHz nominal.
- rst, input, 1: asynchronous, active-high reset.
- rx_en, input, 1: receive enable. Low forces IDLE and ignores the bus.
- ps2_clk, input, 1: raw PS/2 clock pin, asynchronous.
- ps2_data, input, 1: raw PS/2 data pin, asynchronous.
- rx_data, output, 8: last received byte.
- rx_done, output, 1: one-cycle pulse when a complete frame has been received.
- rx_parity_err, output, 1: parity error flag for the last frame; valid with rx_done.
- rx_frame_err, output, 1: stop-bit error flag for the last frame; valid with rx_done.
- rx_timeout, output, 1: one-cycle pulse when a partial frame is discarded.
- rx_busy, output, 1: high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE; shift register, bit counter and timeout counter clear.
  - Both synchronisers and the filter load 1 (idle bus level).
  - Outputs: rx_data=8'h00, rx_done=0, rx_parity_err=0, rx_frame_err=0, rx_timeout=0, rx_busy=0.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchroniser.
  - Filtered clock level toggles only after FILTER_LEN consecutive samples differ from the current level; the run counter restarts on any mismatch.
  - fall_evt is a one-cycle pulse on a 1->0 transition of the filtered clock. It lags the pin by 2+FILTER_LEN cycles.
  - Data is sampled from the synchronised ps2_data in the cycle fall_evt is high.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall_evt with data=0 (start bit), go to DATA with bit_cnt=0. On fall_evt with data=1, stay in IDLE (spurious edge).
  - DATA: on each fall_evt, shift right with the new bit into bit7 and increment bit_cnt. After the 8th bit, go to PARITY.
  - PARITY: on fall_evt, latch the parity bit and go to STOP.
  - STOP: on fall_evt, go to IDLE. In the next cycle, assert rx_done for exactly one cycle, load rx_data from the shift register, and set:
    - rx_parity_err = ~(^shift ^ parity_bit)
    - rx_frame_err = ~stop_bit
- Error handling:
  - rx_done is asserted on every completed frame, errored or not; the consumer decides whether to discard.
  - rx_data and both error flags hold until the next rx_done.
- Timeout:
  - The counter runs only outside IDLE and clears on every fall_evt.
  - When it reaches TIMEOUT_CYCLES-1: FSM goes to IDLE, the partial frame is discarded, rx_timeout pulses for one cycle, rx_done stays 0, and rx_data and the flags are unchanged.
- rx_en low:
  - Next cycle the FSM is in IDLE, counters clear, and the partial frame is discarded with no rx_done and no rx_timeout.
  - fall_evt is ignored while rx_en=0. The filter keeps tracking the line.
- Simultaneous events:
  - Reset dominates everything.
  - rx_en=0 dominates fall_evt and timeout.
  - fall_evt in the same cycle as timeout expiry: the edge wins, and the counter clears.
- Reset mid-frame: the frame is lost and no strobe is produced. The first full frame after reset release is received normally.
- Bus timing: no assumption beyond PS/2 limits (10–16.7 kHz). Any ps2_clk half-period longer than FILTER_LEN+3 cycles must be accepted.

Test Plan:
Bench settings: clk 50 MHz, PS/2 half-period 40 us, FILTER_LEN=8.
- Frame 0x1C: bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1 -> one rx_done pulse, rx_data=8'h1C, rx_parity_err=0, rx_frame_err=0, rx_busy low after STOP.
- Frame 0xF0 sent with parity 0 (correct is 1) -> rx_done, rx_data=8'hF0, rx_parity_err=1. Then frame 0x5A with parity 1 -> rx_parity_err=0.
- Frame 0x12 with stop bit 0 -> rx_done, rx_frame_err=1, rx_data=8'h12.
- Inject a 3-cycle ps2_clk low glitch in IDLE and another mid-DATA -> no state change, no extra bit shifted. A following 0x1C frame is received correctly.
- Stop the bus after start plus 4 data bits and hold for 50000 cycles -> exactly one rx_timeout pulse, no rx_done, rx_busy=0. A following 0x5A frame is received correctly.
- Mid-frame checks:
  - Assert rst for 1 cycle after 5 bits -> outputs at reset values, no rx_done; the next 0x1C frame is received.
  - Drop rx_en after 3 bits -> IDLE, no rx_done, no rx_timeout.

Source files
------------

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: synchronises and deglitches the bus, then
// deserialises start / 8 data (LSB first) / odd parity / stop into a byte strobe.
module ps2_rx_frame #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_en,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_parity_err,
    output logic       rx_frame_err,
    output logic       rx_timeout,
    output logic       rx_busy
);

    localparam int RUN_W = $clog2(FILTER_LEN + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Input conditioning registers
    logic             clk_meta_q,  clk_meta_d;
    logic             clk_sync_q,  clk_sync_d;
    logic             data_meta_q, data_meta_d;
    logic             data_sync_q, data_sync_d;
    logic             filt_q,      filt_d;
    logic [RUN_W-1:0] run_q,       run_d;
    logic             fall_evt_q,  fall_evt_d;

    // Frame FSM registers
    state_t           state_q,      state_d;
    logic [7:0]       shift_q,      shift_d;
    logic [2:0]       bit_cnt_q,    bit_cnt_d;
    logic             parity_q,     parity_d;
    logic [CNT_W-1:0] tmo_cnt_q,    tmo_cnt_d;
    logic [7:0]       rx_data_q,    rx_data_d;
    logic             done_q,       done_d;
    logic             perr_q,       perr_d;
    logic             ferr_q,       ferr_d;
    logic             tmo_pulse_q,  tmo_pulse_d;

    // NOTE: every variable gets a default at the top of an always_comb so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        clk_meta_d  = ps2_clk;
        clk_sync_d  = clk_meta_q;
        data_meta_d = ps2_data;
        data_sync_d = data_meta_q;

        filt_d     = filt_q;
        run_d      = '0;
        fall_evt_d = 1'b0;
        // Any sample agreeing with the current level restarts the run.
        if (clk_sync_q != filt_q) begin
            if (run_q == RUN_W'(FILTER_LEN - 1)) begin
                filt_d     = ~filt_q;
                fall_evt_d = filt_q;
            end else begin
                run_d = run_q + RUN_W'(1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        parity_d    = parity_q;
        tmo_cnt_d   = tmo_cnt_q;
        rx_data_d   = rx_data_q;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        done_d      = 1'b0;
        tmo_pulse_d = 1'b0;

        if (!rx_en) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            tmo_cnt_d = '0;
        end else if (fall_evt_q) begin
            // An edge always beats a simultaneous timeout expiry.
            tmo_cnt_d = '0;
            unique case (state_q)
                IDLE: begin
                    if (!data_sync_q) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {data_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    parity_d = data_sync_q;
                    state_d  = STOP;
                end
                STOP: begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    rx_data_d = shift_q;
                    perr_d    = ~(^shift_q ^ parity_q);
                    ferr_d    = ~data_sync_q;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                state_d     = IDLE;
                bit_cnt_d   = '0;
                tmo_cnt_d   = '0;
                tmo_pulse_d = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
            end
        end else begin
            tmo_cnt_d = '0;
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            filt_q      <= 1'b1;
            run_q       <= '0;
            fall_evt_q  <= 1'b0;
        end else begin
            clk_meta_q  <= clk_meta_d;
            clk_sync_q  <= clk_sync_d;
            data_meta_q <= data_meta_d;
            data_sync_q <= data_sync_d;
            filt_q      <= filt_d;
            run_q       <= run_d;
            fall_evt_q  <= fall_evt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            parity_q    <= 1'b0;
            tmo_cnt_q   <= '0;
            rx_data_q   <= '0;
            done_q      <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            tmo_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            parity_q    <= parity_d;
            tmo_cnt_q   <= tmo_cnt_d;
            rx_data_q   <= rx_data_d;
            done_q      <= done_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            tmo_pulse_q <= tmo_pulse_d;
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_done       = done_q;
    assign rx_parity_err = perr_q;
    assign rx_frame_err  = ferr_q;
    assign rx_timeout    = tmo_pulse_q;
    assign rx_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Bench for ps2_rx_frame: bus-level frame driver feeding a scoreboard queue,
// independent monitor popping expected results on each rx_done / rx_timeout.
`timescale 1ns/1ps
module tb_ps2_rx_frame;

    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 1000;
    localparam int CNT_W          = 16;
    // Shortened bus half-period (still well above FILTER_LEN+3) keeps the run short.
    localparam int HALF           = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_en = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_parity_err;
    logic       rx_frame_err;
    logic       rx_timeout;
    logic       rx_busy;

    ps2_rx_frame #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_en        (rx_en),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .rx_data      (rx_data),
        .rx_done      (rx_done),
        .rx_parity_err(rx_parity_err),
        .rx_frame_err (rx_frame_err),
        .rx_timeout   (rx_timeout),
        .rx_busy      (rx_busy)
    );

    always #10 clk = ~clk;

    typedef struct {
        bit         is_timeout;
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] last_exp_data = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_done) begin
                if (exp_q.size() == 0 || exp_q[0].is_timeout) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rx_done: got data %0h, expected no strobe", rx_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rx_data", rx_data, mon_e.data);
                    check("rx_parity_err", rx_parity_err, mon_e.perr);
                    check("rx_frame_err", rx_frame_err, mon_e.ferr);
                end
            end
            if (rx_timeout) begin
                if (exp_q.size() == 0 || !exp_q[0].is_timeout) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rx_timeout: got pulse, expected none");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rx_timeout_data_hold", rx_data, mon_e.data);
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_bit(input logic b, input bit glitch);
        ps2_data = b;
        if (glitch) begin
            wait_cyc(8);
            ps2_clk = 1'b0;
            wait_cyc(3);
            ps2_clk = 1'b1;
            wait_cyc(HALF - 11);
        end else begin
            wait_cyc(HALF);
        end
        ps2_clk = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    // Sends the first n bits of a frame; bit 0 is the start bit.
    task automatic send_bits(input logic [7:0] d, input logic par, input logic stop,
                             input int n, input int glitch_at);
        logic [10:0] bits;
        bits = {stop, par, d, 1'b0};
        for (int i = 0; i < n; i++) begin
            bus_bit(bits[i], i == glitch_at);
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input int glitch_at);
        exp_t e;
        e.is_timeout  = 1'b0;
        e.data        = d;
        e.perr        = (($countones(d) + int'(par)) % 2) == 0;
        e.ferr        = !stop;
        exp_q.push_back(e);
        last_exp_data = d;
        send_bits(d, par, stop, 11, glitch_at);
        wait_cyc(HALF);
        check("rx_busy_after_frame", rx_busy, 1'b0);
    endtask

    initial begin
        exp_t e;
        logic [7:0] d;
        logic       par;
        logic       stop;

        wait_cyc(5);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_done", rx_done, 1'b0);
        check("reset_rx_busy", rx_busy, 1'b0);
        check("reset_rx_timeout", rx_timeout, 1'b0);
        rst = 1'b0;
        wait_cyc(20);

        send_frame(8'h1C, 1'b0, 1'b1, -1);
        send_frame(8'hF0, 1'b0, 1'b1, -1);
        send_frame(8'h5A, 1'b1, 1'b1, -1);
        send_frame(8'h12, 1'b1, 1'b0, -1);

        // Short clock glitches in IDLE and inside the data bits.
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(30);
        check("glitch_idle_busy", rx_busy, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1, 4);
        send_frame(8'h1C, 1'b0, 1'b1, -1);

        // Stalled frame: start + 4 data bits, then idle bus.
        send_bits(8'hA5, 1'b1, 1'b1, 5, -1);
        wait_cyc(5);
        check("busy_mid_frame", rx_busy, 1'b1);
        e.is_timeout = 1'b1;
        e.data       = last_exp_data;
        e.perr       = 1'b0;
        e.ferr       = 1'b0;
        exp_q.push_back(e);
        wait_cyc(TIMEOUT_CYCLES + 50);
        check("timeout_busy", rx_busy, 1'b0);
        check("timeout_data_hold", rx_data, last_exp_data);
        send_frame(8'h5A, 1'b1, 1'b1, -1);

        // Errored frame, then a reset in the middle of the next frame.
        send_frame(8'hF0, 1'b0, 1'b1, -1);
        send_bits(8'h33, 1'b1, 1'b1, 6, -1);
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        wait_cyc(1);
        check("midreset_rx_data", rx_data, 8'h00);
        check("midreset_parity_err", rx_parity_err, 1'b0);
        check("midreset_frame_err", rx_frame_err, 1'b0);
        check("midreset_busy", rx_busy, 1'b0);
        last_exp_data = 8'h00;
        wait_cyc(2 * HALF);
        send_frame(8'h1C, 1'b0, 1'b1, -1);

        // Receive disabled after 3 data bits; the rest of the frame is ignored.
        send_bits(8'hC3, 1'b1, 1'b1, 4, -1);
        rx_en = 1'b0;
        wait_cyc(2);
        check("rx_en_low_busy", rx_busy, 1'b0);
        for (int i = 4; i < 11; i++) begin
            bus_bit(i >= 9 ? 1'b1 : 1'b0, 1'b0);
        end
        ps2_data = 1'b1;
        wait_cyc(HALF);
        check("rx_en_low_busy_after", rx_busy, 1'b0);
        rx_en = 1'b1;
        wait_cyc(2 * HALF);
        send_frame(8'h5A, 1'b1, 1'b1, -1);

        // Random frames: occasional bad parity and bad stop bits.
        for (int n = 0; n < 16; n++) begin
            d    = 8'($urandom);
            par  = ~^d;
            if ($urandom_range(0, 3) == 0) par = ~par;
            stop = ($urandom_range(0, 4) != 0);
            send_frame(d, par, stop, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : -1);
        end

        wait_cyc(200);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
